// File: rtl/stumps_bist_ctrl.sv
// STUMPS self-test sequencer: schedules scan shift/capture, LFSR stepping and MISR compaction.
// Outputs are registered decodes of the current state, so they trail the state by one cycle.
module stumps_bist_ctrl #(
    parameter int unsigned CHAIN_LEN = 8,
    parameter int unsigned CNT_W     = 4,
    parameter int unsigned PAT_W     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [PAT_W-1:0] num_patterns,
    output logic             TC,
    output logic             lfsr_load,
    output logic             lfsr_en,
    output logic             misr_clr,
    output logic             misr_en,
    output logic             busy,
    output logic             done,
    output logic [PAT_W-1:0] pat_idx
);

    typedef enum logic [2:0] {
        StIdle,
        StInit,
        StShift,
        StCapture,
        StUnload,
        StDone
    } state_e;

    localparam logic [CNT_W-1:0] ShiftLast = CNT_W'(CHAIN_LEN - 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   shift_cnt_q, shift_cnt_d;
    logic [PAT_W-1:0]   pat_cnt_q, pat_cnt_d;
    logic [PAT_W-1:0]   pat_tgt_q, pat_tgt_d;
    logic               aborting;

    logic tc_q, lfsr_load_q, lfsr_en_q, misr_clr_q, misr_en_q, busy_q, done_q;
    logic tc_d, lfsr_load_d, lfsr_en_d, misr_clr_d, misr_en_d, busy_d, done_d;
    logic [PAT_W-1:0] pat_idx_q;

    assign aborting = abort && (state_q != StIdle);

    // State, counters and output registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= StIdle;
            shift_cnt_q <= '0;
            pat_cnt_q   <= '0;
            pat_tgt_q   <= '0;
            tc_q        <= 1'b0;
            lfsr_load_q <= 1'b0;
            lfsr_en_q   <= 1'b0;
            misr_clr_q  <= 1'b0;
            misr_en_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pat_idx_q   <= '0;
        end else begin
            state_q     <= state_d;
            shift_cnt_q <= shift_cnt_d;
            pat_cnt_q   <= pat_cnt_d;
            pat_tgt_q   <= pat_tgt_d;
            tc_q        <= tc_d;
            lfsr_load_q <= lfsr_load_d;
            lfsr_en_q   <= lfsr_en_d;
            misr_clr_q  <= misr_clr_d;
            misr_en_q   <= misr_en_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pat_idx_q   <= pat_cnt_q;
        end
    end

    // Next-state and counter logic; abort pre-empts every transition.
    always_comb begin
        state_d     = state_q;
        shift_cnt_d = shift_cnt_q;
        pat_cnt_d   = pat_cnt_q;
        pat_tgt_d   = pat_tgt_q;
        if (aborting) begin
            state_d     = StIdle;
            shift_cnt_d = '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (start) begin
                        state_d   = StInit;
                        pat_tgt_d = num_patterns;
                        pat_cnt_d = '0;
                    end
                end
                StInit: begin
                    shift_cnt_d = '0;
                    state_d     = (pat_tgt_q == '0) ? StDone : StShift;
                end
                StShift: begin
                    if (shift_cnt_q == ShiftLast) begin
                        shift_cnt_d = '0;
                        state_d     = StCapture;
                    end else begin
                        shift_cnt_d = shift_cnt_q + 1'b1;
                    end
                end
                StCapture: begin
                    pat_cnt_d = pat_cnt_q + 1'b1;
                    state_d   = (pat_cnt_d == pat_tgt_q) ? StUnload : StShift;
                end
                StUnload: begin
                    if (shift_cnt_q == ShiftLast) begin
                        shift_cnt_d = '0;
                        state_d     = StDone;
                    end else begin
                        shift_cnt_d = shift_cnt_q + 1'b1;
                    end
                end
                StDone:  state_d = StIdle;
                default: state_d = StIdle;
            endcase
        end
    end

    // Moore output decode of the current state, registered above.
    always_comb begin
        tc_d        = 1'b0;
        lfsr_load_d = 1'b0;
        lfsr_en_d   = 1'b0;
        misr_clr_d  = 1'b0;
        misr_en_d   = 1'b0;
        busy_d      = 1'b0;
        done_d      = 1'b0;
        if (!aborting) begin
            case (state_q)
                StInit: begin
                    lfsr_load_d = 1'b1;
                    misr_clr_d  = 1'b1;
                    busy_d      = 1'b1;
                end
                StShift: begin
                    tc_d      = 1'b1;
                    lfsr_en_d = 1'b1;
                    // First pattern's shift unloads uninitialised chain contents.
                    misr_en_d = (pat_cnt_q != '0);
                    busy_d    = 1'b1;
                end
                StCapture: busy_d = 1'b1;
                StUnload: begin
                    tc_d      = 1'b1;
                    misr_en_d = 1'b1;
                    busy_d    = 1'b1;
                end
                StDone: begin
                    done_d = 1'b1;
                    busy_d = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign TC        = tc_q;
    assign lfsr_load = lfsr_load_q;
    assign lfsr_en   = lfsr_en_q;
    assign misr_clr  = misr_clr_q;
    assign misr_en   = misr_en_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pat_idx   = pat_idx_q;

endmodule

// File: tb/tb_stumps_bist_ctrl.sv
// Bench for stumps_bist_ctrl: per-cycle comparison against a run-schedule model,
// table-driven run checks, directed corner sequences and randomized traffic.
module tb_stumps_bist_ctrl;

    localparam int L = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [7:0] num_patterns = '0;
    logic       TC, lfsr_load, lfsr_en, misr_clr, misr_en, busy, done;
    logic [7:0] pat_idx;

    stumps_bist_ctrl #(
        .CHAIN_LEN(L),
        .CNT_W    (4),
        .PAT_W    (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .abort       (abort),
        .num_patterns(num_patterns),
        .TC          (TC),
        .lfsr_load   (lfsr_load),
        .lfsr_en     (lfsr_en),
        .misr_clr    (misr_clr),
        .misr_en     (misr_en),
        .busy        (busy),
        .done        (done),
        .pat_idx     (pat_idx)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       tc;
        logic       load;
        logic       len;
        logic       clr;
        logic       men;
        logic       busy;
        logic       done;
        logic [7:0] pat;
    } outv_t;

    typedef struct {
        int n;
        int abort_at;   // edge index after start at which abort is sampled; 0 = none
        int exp_done;   // edge index after start after which done is high; 0 = never
        int exp_pat;
    } run_t;

    outv_t sched[$];
    logic [7:0] last_pat = '0;
    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int cyc = 0;
    string phase = "reset";

    function automatic outv_t mk(logic tc, logic ld, logic le, logic mc, logic me,
                                 logic bs, logic dn, logic [7:0] pat);
        outv_t v;
        v = '{tc: tc, load: ld, len: le, clr: mc, men: me, busy: bs, done: dn, pat: pat};
        return v;
    endfunction

    // Visible output sequence of one run, one entry per cycle, from INIT to DONE.
    function automatic void push_run(int n);
        sched.push_back(mk(0, 1, 0, 1, 0, 1, 0, 8'd0));
        for (int p = 0; p < n; p++) begin
            for (int s = 0; s < L; s++) sched.push_back(mk(1, 0, 1, 0, p > 0, 1, 0, 8'(p)));
            sched.push_back(mk(0, 0, 0, 0, 0, 1, 0, 8'(p)));
        end
        if (n > 0)
            for (int s = 0; s < L; s++) sched.push_back(mk(1, 0, 0, 0, 1, 1, 0, 8'(n)));
        sched.push_back(mk(0, 0, 0, 0, 0, 1, 1, 8'(n)));
    endfunction

    // One clock edge: advance model with current inputs, then compare outputs.
    task automatic step();
        outv_t exp_v, act_v;
        if (!rst) begin
            sched.delete();
            last_pat = '0;
            exp_v = '0;
        end else if (sched.size() != 0 && abort) begin
            last_pat = sched[0].pat;
            sched.delete();
            exp_v = mk(0, 0, 0, 0, 0, 0, 0, last_pat);
        end else if (sched.size() == 0) begin
            exp_v = mk(0, 0, 0, 0, 0, 0, 0, last_pat);
            if (start) push_run(int'(num_patterns));
        end else begin
            exp_v = sched.pop_front();
            last_pat = exp_v.pat;
        end
        @(posedge clk);
        #1;
        cyc++;
        act_v = mk(TC, lfsr_load, lfsr_en, misr_clr, misr_en, busy, done, pat_idx);
        checks++;
        if (act_v !== exp_v) begin
            errors++;
            $display("FAIL %s cycle %0d outputs got %h expected %h", phase, cyc, act_v, exp_v);
        end
        if (done === 1'b1) done_cnt++;
    endtask

    task automatic check(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, act, exp);
        end
    endtask

    run_t runs[6];
    int seen;
    int dones_before;

    initial begin
        runs[0] = '{n: 2,   abort_at: 0,  exp_done: 28,   exp_pat: 2};
        runs[1] = '{n: 0,   abort_at: 0,  exp_done: 2,    exp_pat: 0};
        runs[2] = '{n: 5,   abort_at: 24, exp_done: 0,    exp_pat: 2};
        runs[3] = '{n: 1,   abort_at: 0,  exp_done: 19,   exp_pat: 1};
        runs[4] = '{n: 3,   abort_at: 0,  exp_done: 37,   exp_pat: 3};
        runs[5] = '{n: 255, abort_at: 0,  exp_done: 2305, exp_pat: 255};

        // Reset held with start asserted, then release with start low.
        rst = 1'b0;
        start = 1'b1;
        num_patterns = 8'd4;
        step();
        step();
        check("reset_busy", int'(busy), 0);
        start = 1'b0;
        rst = 1'b1;
        phase = "post_reset_idle";
        repeat (3) step();
        check("idle_after_reset_busy", int'(busy), 0);

        // Table of complete and aborted runs.
        for (int r = 0; r < 6; r++) begin
            phase = $sformatf("run%0d", r);
            num_patterns = 8'(runs[r].n);
            start = 1'b1;
            step();
            start = 1'b0;
            seen = 0;
            dones_before = done_cnt;
            for (int c = 1; c <= 2400; c++) begin
                if (c == runs[r].abort_at) abort = 1'b1;
                step();
                abort = 1'b0;
                if (c == runs[r].abort_at) begin
                    check($sformatf("run%0d_abort_busy", r), int'(busy), 0);
                    check($sformatf("run%0d_abort_tc", r), int'(TC), 0);
                end
                if (done === 1'b1 && seen == 0) seen = c;
                if (runs[r].abort_at != 0 && c >= runs[r].abort_at + 6) break;
                if (runs[r].abort_at == 0 && seen != 0) break;
            end
            check($sformatf("run%0d_done_edge", r), seen, runs[r].exp_done);
            check($sformatf("run%0d_pat_idx", r), int'(pat_idx), runs[r].exp_pat);
            step();
            check($sformatf("run%0d_done_pulses", r), done_cnt - dones_before,
                  runs[r].exp_done != 0 ? 1 : 0);
        end

        // Start with a new count while busy must be ignored.
        phase = "start_while_busy";
        num_patterns = 8'd3;
        start = 1'b1;
        step();
        start = 1'b0;
        dones_before = done_cnt;
        seen = 0;
        for (int c = 1; c <= 60; c++) begin
            if (c == 10) begin
                start = 1'b1;
                num_patterns = 8'd7;
            end
            step();
            start = 1'b0;
            if (done === 1'b1 && seen == 0) seen = c;
        end
        check("busy_start_done_edge", seen, 37);
        check("busy_start_pat_idx", int'(pat_idx), 3);
        check("busy_start_done_pulses", done_cnt - dones_before, 1);

        // Reset during the first visible capture cycle.
        phase = "reset_mid_run";
        num_patterns = 8'd2;
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (10) step();
        check("capture_tc_low", int'(TC), 0);
        check("capture_busy", int'(busy), 1);
        rst = 1'b0;
        step();
        rst = 1'b1;
        check("mid_reset_busy", int'(busy), 0);
        check("mid_reset_pat_idx", int'(pat_idx), 0);
        dones_before = done_cnt;
        repeat (30) step();
        check("mid_reset_no_done", done_cnt - dones_before, 0);

        // Randomized traffic with occasional aborts, restarts and resets.
        phase = "random";
        for (int i = 0; i < 3000; i++) begin
            start = ($urandom_range(0, 7) == 0);
            abort = ($urandom_range(0, 79) == 0);
            rst = ($urandom_range(0, 399) != 0);
            num_patterns = 8'($urandom_range(0, 6));
            step();
        end
        start = 1'b0;
        abort = 1'b0;
        rst = 1'b1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
